// File: rtl/wr_rd_sequencer.sv
// ---------------------------------------------------------------------------
// wr_rd_sequencer
//
// Runs one buffer sequence: it writes DEPTH words as the source offers them,
// waits WAIT_CYCLES clocks so the stored data can settle, and then reads all
// DEPTH words back in address order.
//
// Optional feature (macro WR_RD_SEQUENCER_LOOP_EN):
//   When the macro is defined, the end of the read phase goes straight back
//   to the write phase at address 0. The sequence then repeats until abort or
//   reset, and done is never raised.
//   When the macro is undefined, the end of the read phase goes to DONE.
//
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous active-low reset
//   start         in   1       begin a sequence (only seen in IDLE / DONE)
//   abort         in   1       synchronous cancel back to IDLE; beats start
//   wr_valid      in   1       source has a word ready this cycle
//   wr_en         out  1       write strobe (wr_valid gated by WRITE)
//   wr_addr       out  ADDR_W  write address
//   rd_en         out  1       read strobe (high for every READ cycle)
//   rd_addr       out  ADDR_W  read address
//   rd_data_valid out  1       rd_en delayed one cycle (RAM read latency)
//   busy          out  1       high in WRITE, WAIT and READ
//   done          out  1       level, high in DONE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; all addresses and the wait counter are 0
// WRITE   | accept words from the source until address DEPTH-1 is written
// WAIT    | settle delay that lasts exactly WAIT_CYCLES cycles
// READ    | one read per cycle, addresses 0 .. DEPTH-1
// DONE    | sequence complete; start begins a new one
// ---------------------------------------------------------------------------
module wr_rd_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1000000,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;

    // The strobes and status flags are decoded from the state register, so
    // they change only on a clock edge. The one exception is wr_en, which
    // must follow wr_valid within the same cycle.
    assign wr_en = (state == ST_WRITE) && wr_valid;
    assign rd_en = (state == ST_READ);
    assign busy  = (state == ST_WRITE) || (state == ST_WAIT) || (state == ST_READ);
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            wr_addr       <= '0;
            rd_addr       <= '0;
            wait_cnt      <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            // Registered unconditionally. This keeps rd_data_valid high for
            // the cycle after READ ends, including an abort out of READ.
            rd_data_valid <= rd_en;

            if (abort) begin
                state    <= ST_IDLE;
                wr_addr  <= '0;
                rd_addr  <= '0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state   <= ST_WRITE;
                            wr_addr <= '0;
                        end
                    end
                    ST_WRITE: begin
                        if (wr_valid) begin
                            // The last accepted write lets the address wrap to 0.
                            wr_addr <= wr_addr + ADDR_ONE;
                            if (wr_addr == ADDR_LAST) begin
                                state    <= ST_WAIT;
                                wait_cnt <= '0;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_LAST) begin
                            state    <= ST_READ;
                            rd_addr  <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_ONE;
                        end
                    end
                    ST_READ: begin
                        rd_addr <= rd_addr + ADDR_ONE;
                        if (rd_addr == ADDR_LAST) begin
`ifdef WR_RD_SEQUENCER_LOOP_EN
                            state   <= ST_WRITE;
                            wr_addr <= '0;
`else
                            state   <= ST_DONE;
`endif
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wr_rd_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for wr_rd_sequencer with ADDR_W=5 and WAIT_CYCLES=4.
// The reference model tracks which phase the sequence is in and counts the
// accepted writes, the elapsed wait cycles and the issued reads. Every output
// is checked each cycle against values derived from those counts.
// ---------------------------------------------------------------------------
module tb_wr_rd_sequencer;

    localparam int ADDR_W      = 5;
    localparam int DEPTH       = 32;
    localparam int WAIT_CYCLES = 4;
    localparam int CNT_W       = 8;

    localparam int P_IDLE = 0;
    localparam int P_WR   = 1;
    localparam int P_WAIT = 2;
    localparam int P_RD   = 3;
    localparam int P_DONE = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              wr_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_valid;
    logic              busy;
    logic              done;

    wr_rd_sequencer #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .wr_valid      (wr_valid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: phase plus progress counts
    int ph;
    int nwr;
    int nwait;
    int nrd;
    bit m_rdv;

    // tallies of DUT activity over one sequence
    int obs_wr;
    int obs_rd;
    int obs_quiet_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ph    = P_IDLE;
        nwr   = 0;
        nwait = 0;
        nrd   = 0;
        m_rdv = 1'b0;
    endtask

    task automatic check_outputs(input bit wv);
        chk("wr_en",         32'(wr_en),         32'((ph == P_WR) && wv));
        chk("wr_addr",       32'(wr_addr),       32'((ph == P_WR) ? (nwr % DEPTH) : 0));
        chk("rd_en",         32'(rd_en),         32'(ph == P_RD));
        chk("rd_addr",       32'(rd_addr),       32'((ph == P_RD) ? nrd : 0));
        chk("rd_data_valid", 32'(rd_data_valid), 32'(m_rdv));
        chk("busy",          32'(busy),          32'(ph == P_WR || ph == P_WAIT || ph == P_RD));
        chk("done",          32'(done),          32'(ph == P_DONE));
    endtask

    task automatic model_step(input bit st, input bit ab, input bit wv);
        bit next_rdv;
        next_rdv = (ph == P_RD);
        if (ab) begin
            ph = P_IDLE; nwr = 0; nwait = 0; nrd = 0;
        end else begin
            case (ph)
                P_IDLE, P_DONE: if (st) begin ph = P_WR; nwr = 0; end
                P_WR: if (wv) begin
                    nwr++;
                    if (nwr == DEPTH) begin ph = P_WAIT; nwait = 0; end
                end
                P_WAIT: begin
                    nwait++;
                    if (nwait == WAIT_CYCLES) begin ph = P_RD; nrd = 0; end
                end
                P_RD: begin
                    nrd++;
                    if (nrd == DEPTH) begin
`ifdef WR_RD_SEQUENCER_LOOP_EN
                        ph = P_WR; nwr = 0;
`else
                        ph = P_DONE;
`endif
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        m_rdv = next_rdv;
    endtask

    task automatic cycle(input bit st, input bit ab, input bit wv);
        @(negedge clk);
        start    = st;
        abort    = ab;
        wr_valid = wv;
        #1;
        check_outputs(wv);
        if (wr_en === 1'b1) obs_wr++;
        if (rd_en === 1'b1) obs_rd++;
        if (busy === 1'b1 && wr_en === 1'b0 && rd_en === 1'b0) obs_quiet_busy++;
        @(posedge clk);
        model_step(st, ab, wv);
    endtask

    function automatic int cur_n();
        case (ph)
            P_WR:    return nwr;
            P_WAIT:  return nwait;
            P_RD:    return nrd;
            default: return 0;
        endcase
    endfunction

    task automatic run_until(input string tag, input int tph, input int tn, input bit wv);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ph == tph && cur_n() == tn) begin
                hit = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0, wv);
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        wr_valid = 1'b0;
        model_reset();

        // outputs while reset is held
        @(negedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        reset = 1'b1;
        // idle after release: wr_valid alone must not cause a write
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // one full sequence with wr_valid held high
        obs_wr = 0; obs_rd = 0; obs_quiet_busy = 0;
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + WAIT_CYCLES + DEPTH; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("seq_wr_count",   32'(obs_wr),         32'(DEPTH));
        chk("seq_rd_count",   32'(obs_rd),         32'(DEPTH));
        chk("seq_wait_count", 32'(obs_quiet_busy), 32'(WAIT_CYCLES));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

        // start held high: ignored while busy, restarts from DONE
        for (int i = 0; i < 2 * (DEPTH + WAIT_CYCLES + DEPTH) + 6; i++) cycle(1'b1, 1'b0, 1'b1);

        // alternating wr_valid
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        obs_wr = 0;
        for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 1'b0, (i % 2) == 0);
        chk("toggle_wr_count", 32'(obs_wr), 32'(DEPTH));
        for (int i = 0; i < WAIT_CYCLES + 4; i++) cycle(1'b0, 1'b0, 1'b1);

        // abort together with start at read address 10
        run_until("reach_rd10", P_RD, 10, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // asynchronous reset in the middle of WAIT
        cycle(1'b1, 1'b0, 1'b1);
        run_until("reach_wait2", P_WAIT, 2, 1'b1);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy",    32'(busy),          32'd0);
        chk("async_rd_en",   32'(rd_en),         32'd0);
        chk("async_wr_addr", 32'(wr_addr),       32'd0);
        chk("async_rdv",     32'(rd_data_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(i == 0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 8) == 0, ($urandom % 200) == 0, ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_rd_sequencer.md
WR_RD_SEQUENCER -- requirements
Module: wr_rd_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning buffer address width (DEPTH = 2**ADDR_W = 32).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1000000, meaning settle delay between write and read phases; legal range 1 to 2**CNT_W-1.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning wait-counter width.
REQ-004 Ports SHALL be, one per line: clk  in  1  rising-edge clock, the only clock in the block; reset is asynchronous and active-low.
REQ-005 Ports SHALL be: reset  in  1  asynchronous active-low reset.
REQ-006 Ports SHALL be: start  in  1  begin a write/wait/read sequence; abort  in  1  synchronous cancel.
REQ-007 Ports SHALL be: wr_valid  in  1  source has a word ready this cycle.
REQ-008 Ports SHALL be: wr_en  out  1  write strobe; wr_addr  out  ADDR_W  write address.
REQ-009 Ports SHALL be: rd_en  out  1  read strobe; rd_addr  out  ADDR_W  read address; rd_data_valid  out  1  RAM read data valid.
REQ-010 Ports SHALL be: busy  out  1  sequence in progress; done  out  1  sequence complete.

Function
REQ-011 The FSM SHALL have states IDLE, WRITE, WAIT, READ, DONE.
REQ-012 IDLE: start=1 SHALL move to WRITE next cycle with wr_addr=0; otherwise remain.
REQ-013 WRITE: wr_en SHALL equal wr_valid combinationally; wr_addr SHALL increment by 1 on each cycle wr_en=1.
REQ-014 WRITE: the write accepted at wr_addr=DEPTH-1 SHALL move to WAIT next cycle; wr_addr SHALL wrap to 0.
REQ-015 WAIT: wait counter SHALL start at 0 on entry, increment each cycle, and on reaching WAIT_CYCLES-1 move to READ, giving exactly WAIT_CYCLES cycles in WAIT.
REQ-016 READ: rd_en SHALL be 1 every cycle; rd_addr SHALL be 0 on entry and increment each cycle, DEPTH cycles total.
REQ-017 READ: after the cycle with rd_addr=DEPTH-1, FSM SHALL go to DONE (or per REQ-027); rd_addr SHALL wrap to 0.
REQ-018 rd_data_valid SHALL be rd_en registered by one cycle (1-cycle RAM latency), including the cycle after leaving READ.
REQ-019 DONE: done SHALL be 1 (level); start=1 SHALL move to WRITE with wr_addr=0; otherwise remain.
REQ-020 busy SHALL be 1 exactly in WRITE, WAIT, READ; start SHALL be ignored while busy=1.
REQ-021 abort=1 in any state SHALL move to IDLE next cycle, clearing wr_addr, rd_addr, wait counter; abort SHALL override simultaneous start.
REQ-022 wr_en SHALL be 0 outside WRITE; rd_en SHALL be 0 outside READ.
REQ-023 Counter and address arithmetic SHALL be unsigned, at declared width, with no overflow beyond stated wraps.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, wr_addr=0, rd_addr=0, wait counter=0, rd_data_valid=0, regardless of clk.
REQ-025 In reset and after release, outputs SHALL be wr_en=0, rd_en=0, busy=0, done=0 until start.
REQ-026 Reset asserted mid-sequence SHALL discard progress; first start after release SHALL begin at wr_addr=0.

Configuration
REQ-027 With macro WR_RD_SEQUENCER_LOOP_EN defined, READ completion SHALL go directly to WRITE (wr_addr=0), never DONE, repeating until abort or reset; done SHALL stay 0.
REQ-028 Without WR_RD_SEQUENCER_LOOP_EN, READ completion SHALL go to DONE per REQ-019.

Verification (WAIT_CYCLES=4, ADDR_W=5)
REQ-029 reset=0 mid-WAIT, then release -> all outputs 0, IDLE; start -> wr_addr restarts at 0.
REQ-030 start pulse, wr_valid=1 continuously -> 32 wr_en cycles at addresses 0..31, 4 cycles with busy=1 and no strobes, 32 rd_en cycles at 0..31, rd_data_valid lagging 1 cycle, then done=1, busy=0.
REQ-031 wr_valid toggling 1,0,1,0 -> wr_addr advances only on wr_en=1; WAIT entered only after 32nd accepted write.
REQ-032 abort during READ at rd_addr=10 together with start -> IDLE next cycle, rd_en=0, rd_addr=0, busy=0, done=0.
REQ-033 start asserted during WRITE and WAIT -> no effect; in DONE -> new sequence at wr_addr=0, done=0.
REQ-034 With WR_RD_SEQUENCER_LOOP_EN defined -> after rd_addr=31 next cycle is WRITE at wr_addr=0, done never 1, busy stays 1.
